frame_read_sequencer: RTL and testbench

Synchronous controller that reads ADC sample words from an upstream first-word-fall-through-free FIFO (1-cycle read latency), prefixes each frame with a header word, and streams the result to a downstream valid/ready sink. It replaces edge-clocked muxing of header/ADC data with a single-clock sequencer that owns the FIFO read strobe, the header/data selection and the frame-boundary flags. It sits between the ADC capture FIFO and the host/transport packetizer.

---
 rtl/frame_read_sequencer_pkg.sv | 14 +
 rtl/frame_read_sequencer_if.sv | 13 +
 rtl/frame_read_sequencer_out_reg.sv | 36 +++
 rtl/frame_read_sequencer.sv | 92 +++++++++
 tb/tb_frame_read_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_read_sequencer_pkg.sv
// Shared types and default sizing for the frame read sequencer.
package frame_seq_pkg;

  localparam int DEF_DATA_W    = 64;
  localparam int DEF_FRAME_LEN = 200;
  localparam int FRAME_CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

endpackage

// File: rtl/frame_read_sequencer_if.sv
// Downstream valid/ready word stream carrying frame boundary flags.
interface frame_read_sequencer_if #(
  parameter int DATA_W = frame_seq_pkg::DEF_DATA_W
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_sof;
  logic              m_eof;

  modport master (output m_valid, output m_data, output m_sof, output m_eof, input m_ready);
  modport slave  (input m_valid, input m_data, input m_sof, input m_eof, output m_ready);
endinterface

// File: rtl/frame_read_sequencer_out_reg.sv
// Single-entry output register: a load overwrites the entry, otherwise the
// entry is held stable until the sink takes it.
module frame_out_reg #(
  parameter int DATA_W = frame_seq_pkg::DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_sof,
  input  logic              load_eof,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              sof,
  output logic              eof
);

  // Load wins; a drained entry keeps its payload but drops valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      sof   <= 1'b0;
      eof   <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      sof   <= load_sof;
      eof   <= load_eof;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/frame_read_sequencer.sv
// Reads ADC words from a 1-cycle-latency FIFO, prefixes each frame with a
// header word and streams the result to a valid/ready sink.
module frame_read_sequencer
  import frame_seq_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int CNT_W     = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [DATA_W-1:0]      hdr_word,
  input  logic                   ad_empty,
  output logic                   ad_rd,
  input  logic [DATA_W-1:0]      ad_data,
  frame_read_sequencer_if.master m,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  if (FRAME_LEN < 2 || FRAME_LEN > 1024) begin : g_bad_frame_len
    $error("frame_read_sequencer: FRAME_LEN must be within 2..1024");
  end
  if ((1 << CNT_W) < FRAME_LEN) begin : g_bad_cnt_w
    $error("frame_read_sequencer: CNT_W too narrow for FRAME_LEN");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 2);

  state_t            state;
  logic [CNT_W-1:0]  word_cnt;
  logic              rd_pend;
  logic              pend_last;
  logic              slot_free;
  logic              hdr_load;
  logic              out_load;
  logic [DATA_W-1:0] out_data;

  // The read strobe stays combinational so a read issues in the same cycle
  // the slot is seen free; the returning word then lands one cycle later
  // into a register that is guaranteed empty, so pending data and header
  // loads can never collide.
  assign slot_free = !m.m_valid || m.m_ready;
  assign ad_rd     = (state == DATA) && !ad_empty && slot_free && !rd_pend;
  assign hdr_load  = (state == HDR) && slot_free && !rd_pend;
  assign out_load  = rd_pend || hdr_load;
  assign out_data  = rd_pend ? ad_data : hdr_word;
  assign busy      = (state != IDLE) || m.m_valid || rd_pend;

  // Sequencer state, word counter, read-pending tracking and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word_cnt  <= '0;
      rd_pend   <= 1'b0;
      pend_last <= 1'b0;
      frame_cnt <= '0;
    end else begin
      rd_pend   <= ad_rd;
      pend_last <= ad_rd && (word_cnt == LAST_CNT);
      if (m.m_valid && m.m_ready && m.m_sof) frame_cnt <= frame_cnt + 1'b1;
      case (state)
        IDLE: if (enable) state <= HDR;
        HDR: if (hdr_load) begin
          word_cnt <= '0;
          state    <= DATA;
        end
        DATA: if (ad_rd) begin
          word_cnt <= word_cnt + 1'b1;
          if (word_cnt == LAST_CNT) state <= enable ? HDR : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  frame_out_reg #(.DATA_W(DATA_W)) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (out_load),
    .load_data (out_data),
    .load_sof  (hdr_load),
    .load_eof  (rd_pend && pend_last),
    .ready     (m.m_ready),
    .valid     (m.m_valid),
    .data      (m.m_data),
    .sof       (m.m_sof),
    .eof       (m.m_eof)
  );

endmodule

// File: tb/tb_frame_read_sequencer.sv
// Directed bench for frame_read_sequencer with FRAME_LEN=4.
module tb_frame_read_sequencer;

  localparam int DW = 64;
  localparam int FL = 4;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] hdr_word = '0;
  logic          ad_empty;
  logic          ad_rd;
  logic [DW-1:0] ad_data;
  logic          busy;
  logic [15:0]   frame_cnt;

  frame_read_sequencer_if #(.DATA_W(DW)) m_if ();

  frame_read_sequencer #(.DATA_W(DW), .FRAME_LEN(FL), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .hdr_word  (hdr_word),
    .ad_empty  (ad_empty),
    .ad_rd     (ad_rd),
    .ad_data   (ad_data),
    .m         (m_if),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Upstream FIFO model: data appears one cycle after the read strobe.
  logic [DW-1:0] fifo_mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign ad_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (ad_rd && (wr_ptr != rd_ptr)) begin
      ad_data <= fifo_mem[rd_ptr % 64];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [DW-1:0] w);
    fifo_mem[wr_ptr % 64] = w;
    wr_ptr++;
  endtask

  // Accepted-word capture and read strobe counter.
  typedef struct packed {
    logic [DW-1:0] data;
    logic          sof;
    logic          eof;
  } word_t;
  word_t cap[$];
  int    cap_base = 0;
  int    rd_cnt = 0;

  always @(posedge clk) begin
    if (rst_n && m_if.m_valid && m_if.m_ready)
      cap.push_back('{m_if.m_data, m_if.m_sof, m_if.m_eof});
    if (ad_rd) rd_cnt++;
  end

  // Hold-while-stalled and read-gating properties.
  logic          hold_v = 1'b0;
  logic [DW-1:0] hold_d;
  logic          hold_s, hold_e;
  logic          prev_rd = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      hold_v  = 1'b0;
      prev_rd = 1'b0;
    end else begin
      if (hold_v) begin
        check1("hold_valid", m_if.m_valid, 1'b1);
        check64("hold_data", m_if.m_data, hold_d);
        check1("hold_sof", m_if.m_sof, hold_s);
        check1("hold_eof", m_if.m_eof, hold_e);
      end
      if (ad_rd) begin
        check1("rd_slot_free", !m_if.m_valid || m_if.m_ready, 1'b1);
        check1("rd_one_outstanding", prev_rd, 1'b0);
      end
      hold_v  = m_if.m_valid && !m_if.m_ready;
      hold_d  = m_if.m_data;
      hold_s  = m_if.m_sof;
      hold_e  = m_if.m_eof;
      prev_rd = ad_rd;
    end
  end

  // Vector table: header rows drive hdr_word, data rows are pushed into the
  // FIFO; every row is also the expected accepted word.
  typedef struct {
    logic          is_hdr;
    logic [DW-1:0] word;
    logic          sof;
    logic          eof;
  } vec_t;
  vec_t tbl [12];

  task automatic load_frame(input int first);
    for (int i = first; i < first + FL; i++) begin
      if (tbl[i].is_hdr) hdr_word = tbl[i].word;
      else push(tbl[i].word);
    end
  endtask

  task automatic wait_cap(input int n, input string name);
    int k = 0;
    while ((cap.size() < cap_base + n) && (k < 200)) begin
      @(negedge clk);
      k++;
    end
    if (cap.size() < cap_base + n) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timeout, got %0d words required %0d", name, cap.size() - cap_base, n);
    end
  endtask

  task automatic cmp_stream(input int tfirst, input int coff, input int n);
    for (int i = 0; i < n; i++) begin
      if (cap_base + coff + i < cap.size()) begin
        check64($sformatf("word%0d_data", tfirst + i), cap[cap_base + coff + i].data, tbl[tfirst + i].word);
        check1($sformatf("word%0d_sof", tfirst + i), cap[cap_base + coff + i].sof, tbl[tfirst + i].sof);
        check1($sformatf("word%0d_eof", tfirst + i), cap[cap_base + coff + i].eof, tbl[tfirst + i].eof);
      end else begin
        n_cmp++;
        n_fail++;
        $display("FAIL word%0d_missing: got none required %h", tfirst + i, tbl[tfirst + i].word);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    enable = 1'b0;
    m_if.m_ready = 1'b0;
    wr_ptr = rd_ptr;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cap_base = cap.size();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r0, k, v_seen;
    tbl[0]  = '{1'b1, 64'hA5A5, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 64'd1,    1'b0, 1'b0};
    tbl[2]  = '{1'b0, 64'd2,    1'b0, 1'b0};
    tbl[3]  = '{1'b0, 64'd3,    1'b0, 1'b1};
    tbl[4]  = '{1'b1, 64'hA5A5, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 64'd4,    1'b0, 1'b0};
    tbl[6]  = '{1'b0, 64'd5,    1'b0, 1'b0};
    tbl[7]  = '{1'b0, 64'd6,    1'b0, 1'b1};
    tbl[8]  = '{1'b1, 64'h1234, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 64'd7,    1'b0, 1'b0};
    tbl[10] = '{1'b0, 64'd8,    1'b0, 1'b0};
    tbl[11] = '{1'b0, 64'd9,    1'b0, 1'b1};

    m_if.m_ready = 1'b0;

    // Idle with a full FIFO: nothing may move.
    repeat (3) @(negedge clk);
    load_frame(0);
    rst_n = 1'b1;
    cap_base = cap.size();
    repeat (10) @(negedge clk);
    check_int("idle_rd_pulses", rd_cnt, 0);
    check1("idle_ad_rd", ad_rd, 1'b0);
    check1("idle_m_valid", m_if.m_valid, 1'b0);
    check64("idle_m_data", m_if.m_data, 64'd0);
    check1("idle_m_sof", m_if.m_sof, 1'b0);
    check1("idle_m_eof", m_if.m_eof, 1'b0);
    check1("idle_busy", busy, 1'b0);
    check_int("idle_frame_cnt", int'(frame_cnt), 0);

    // Streaming frame, header latency, then enable dropped during frame 2.
    m_if.m_ready = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    check1("hdr_lat_t1_valid", m_if.m_valid, 1'b0);
    check1("hdr_lat_t1_busy", busy, 1'b1);
    @(negedge clk);
    check1("hdr_lat_t2_valid", m_if.m_valid, 1'b1);
    check64("hdr_lat_t2_data", m_if.m_data, 64'hA5A5);
    check1("hdr_lat_t2_sof", m_if.m_sof, 1'b1);
    wait_cap(4, "frame1");
    check_int("frame1_cnt", int'(frame_cnt), 1);
    wait_cap(5, "frame2_hdr");
    check_int("frame2_hdr_cnt", int'(frame_cnt), 2);
    enable = 1'b0;
    for (int i = 5; i < 8; i++) push(tbl[i].word);
    wait_cap(8, "frame2");
    cmp_stream(0, 0, 8);
    repeat (6) @(negedge clk);
    check1("drop_en_busy", busy, 1'b0);
    check1("drop_en_valid", m_if.m_valid, 1'b0);
    check_int("drop_en_frame_cnt", int'(frame_cnt), 2);
    check_int("drop_en_words", cap.size() - cap_base, 8);

    // Backpressure: m_ready toggles every cycle.
    do_reset();
    load_frame(0);
    enable = 1'b1;
    k = 0;
    while ((cap.size() < cap_base + 4) && (k < 200)) begin
      @(negedge clk);
      m_if.m_ready = ~m_if.m_ready;
      k++;
    end
    cmp_stream(0, 0, 4);
    check_int("toggle_frame_cnt", int'(frame_cnt), 1);

    // FIFO runs dry after two data words.
    do_reset();
    hdr_word = 64'hA5A5;
    push(64'd1);
    push(64'd2);
    m_if.m_ready = 1'b1;
    enable = 1'b1;
    wait_cap(3, "stall_pre");
    r0 = rd_cnt;
    v_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_if.m_valid) v_seen++;
    end
    check_int("stall_rd_pulses", rd_cnt - r0, 0);
    check_int("stall_valid_cycles", v_seen, 0);
    push(64'd3);
    #1;
    check1("resume_rd", ad_rd, 1'b1);
    @(negedge clk);
    check1("resume_t1_rd", ad_rd, 1'b0);
    check1("resume_t1_valid", m_if.m_valid, 1'b0);
    @(negedge clk);
    check1("resume_t2_valid", m_if.m_valid, 1'b1);
    check64("resume_t2_data", m_if.m_data, 64'd3);
    check1("resume_t2_eof", m_if.m_eof, 1'b1);
    wait_cap(4, "stall_frame");
    cmp_stream(0, 0, 4);

    // Reset with a read in flight.
    do_reset();
    load_frame(0);
    m_if.m_ready = 1'b1;
    enable = 1'b1;
    r0 = rd_cnt;
    k = 0;
    while ((rd_cnt == r0) && (k < 100)) begin
      @(negedge clk);
      k++;
    end
    check1("midrst_pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("midrst_ad_rd", ad_rd, 1'b0);
    check1("midrst_valid", m_if.m_valid, 1'b0);
    check64("midrst_data", m_if.m_data, 64'd0);
    check1("midrst_sof", m_if.m_sof, 1'b0);
    check1("midrst_eof", m_if.m_eof, 1'b0);
    check1("midrst_busy", busy, 1'b0);
    check_int("midrst_frame_cnt", int'(frame_cnt), 0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    wr_ptr = rd_ptr;
    rst_n = 1'b1;
    cap_base = cap.size();
    load_frame(8);
    enable = 1'b1;
    wait_cap(4, "post_rst_frame");
    cmp_stream(8, 0, 4);
    check_int("post_rst_frame_cnt", int'(frame_cnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
